// File: rtl/vector_sequencer.sv
// vector_sequencer: fetches vector words plus opcode/param from vector memory,
// decodes REPEAT / STOP / JUMP / MARK opcodes and streams one vector per tester
// cycle to the timing generator over a valid/ready handshake.
//
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   start, abort      pattern control pulses (abort has priority)
//   vec_count         number of vectors; reaching index==vec_count ends the pattern
//   mem_rd_en/addr    memory read request (data returns one cycle later)
//   mem_rd_data/op/param  {wft,period,wfc}, opcode and opcode parameter
//   vec_valid/ready   handshake to the timing generator
//   vec_wft/period/wfc    presented vector fields
//   vector_index      memory address of the presented vector
//   cycle_number      accepted vectors since start
//   busy, done        pattern running / one-cycle normal-end pulse
//   breakpoint        sticky: STOP opcode completed
//   op_error          sticky: REPEAT and JUMP set on the same vector
module vector_sequencer #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WFT_W    = 4,
    parameter int unsigned WFC_W    = 184,
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    input  logic [ADDR_W-1:0]                 vec_count,
    output logic                              mem_rd_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    input  logic [WFT_W+PERIOD_W+WFC_W-1:0]   mem_rd_data,
    input  logic [3:0]                        mem_rd_op,
    input  logic [CNT_W-1:0]                  mem_rd_param,
    output logic                              vec_valid,
    input  logic                              vec_ready,
    output logic [WFT_W-1:0]                  vec_wft,
    output logic [PERIOD_W-1:0]               vec_period,
    output logic [WFC_W-1:0]                  vec_wfc,
    output logic [ADDR_W-1:0]                 vector_index,
    output logic [CNT_W-1:0]                  cycle_number,
    output logic                              busy,
    output logic                              done,
    output logic                              breakpoint,
    output logic                              op_error
);

    localparam int unsigned DATA_W = WFT_W + PERIOD_W + WFC_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [ADDR_W-1:0]   index_q,      index_d;
    logic [ADDR_W-1:0]   mark_q,       mark_d;
    logic [CNT_W-1:0]    loop_cnt_q,   loop_cnt_d;
    logic                loop_act_q,   loop_act_d;
    logic [CNT_W-1:0]    rep_q,        rep_d;
    logic                stop_q,       stop_d;
    logic                jump_q,       jump_d;
    logic [CNT_W-1:0]    param_q,      param_d;
    logic [CNT_W-1:0]    cycle_q,      cycle_d;
    logic                vec_valid_q,  vec_valid_d;
    logic [WFT_W-1:0]    wft_q,        wft_d;
    logic [PERIOD_W-1:0] period_q,     period_d;
    logic [WFC_W-1:0]    wfc_q,        wfc_d;
    logic                mem_rd_en_q,  mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                bp_q,         bp_d;
    logic                err_q,        err_d;

    // Helpers for the accept decision in ISSUE
    logic [ADDR_W-1:0]   idx_inc;
    logic [CNT_W-1:0]    loop_src;
    logic                jump_take;

    assign idx_inc  = ADDR_W'(index_q + ADDR_W'(1));
    // First visit of a JUMP vector loads the loop count from its parameter
    assign loop_src = loop_act_q ? loop_cnt_q : param_q;
    assign jump_take = jump_q && (loop_src != '0);

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        mark_d      = mark_q;
        loop_cnt_d  = loop_cnt_q;
        loop_act_d  = loop_act_q;
        rep_d       = rep_q;
        stop_d      = stop_q;
        jump_d      = jump_q;
        param_d     = param_q;
        cycle_d     = cycle_q;
        wft_d       = wft_q;
        period_d    = period_q;
        wfc_d       = wfc_q;
        bp_d        = bp_q;
        err_d       = err_q;
        done_d      = 1'b0;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        vec_valid_d = 1'b0;
        busy_d      = 1'b0;

        if (abort) begin
            // Abort beats everything, including a simultaneous accept or start
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cycle_d    = '0;
                        index_d    = '0;
                        mark_d     = '0;
                        loop_cnt_d = '0;
                        loop_act_d = 1'b0;
                        rep_d      = '0;
                        bp_d       = 1'b0;
                        err_d      = 1'b0;
                        if (vec_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    state_d = S_LOAD;
                end

                S_LOAD: begin
                    wft_d    = mem_rd_data[DATA_W-1 -: WFT_W];
                    period_d = mem_rd_data[WFC_W +: PERIOD_W];
                    wfc_d    = mem_rd_data[WFC_W-1:0];
                    stop_d   = mem_rd_op[1];
                    // REPEAT wins when both REPEAT and JUMP are set
                    jump_d   = mem_rd_op[2] & ~mem_rd_op[0];
                    param_d  = mem_rd_param;
                    // rep holds the number of extra issues beyond the first
                    if (mem_rd_op[0] && (mem_rd_param > CNT_W'(1))) begin
                        rep_d = CNT_W'(mem_rd_param - CNT_W'(1));
                    end else begin
                        rep_d = '0;
                    end
                    if (mem_rd_op[0] && mem_rd_op[2]) begin
                        err_d = 1'b1;
                    end
                    if (mem_rd_op[3]) begin
                        mark_d = index_q;
                    end
                    state_d = S_ISSUE;
                end

                S_ISSUE: begin
                    if (vec_ready) begin
                        cycle_d = CNT_W'(cycle_q + CNT_W'(1));
                        if (rep_q != '0) begin
                            rep_d = CNT_W'(rep_q - CNT_W'(1));
                        end else if (stop_q) begin
                            bp_d    = 1'b1;
                            state_d = S_IDLE;
                        end else if (jump_take) begin
                            loop_act_d = 1'b1;
                            loop_cnt_d = CNT_W'(loop_src - CNT_W'(1));
                            index_d    = mark_q;
                            state_d    = S_FETCH;
                        end else begin
                            if (jump_q) begin
                                loop_act_d = 1'b0;
                            end
                            index_d = idx_inc;
                            if (idx_inc == vec_count) begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs derived from the next state so they are registered with it
        if (state_d == S_FETCH) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = index_d;
        end
        vec_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            mark_q      <= '0;
            loop_cnt_q  <= '0;
            loop_act_q  <= 1'b0;
            rep_q       <= '0;
            stop_q      <= 1'b0;
            jump_q      <= 1'b0;
            param_q     <= '0;
            cycle_q     <= '0;
            vec_valid_q <= 1'b0;
            wft_q       <= '0;
            period_q    <= '0;
            wfc_q       <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bp_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            mark_q      <= mark_d;
            loop_cnt_q  <= loop_cnt_d;
            loop_act_q  <= loop_act_d;
            rep_q       <= rep_d;
            stop_q      <= stop_d;
            jump_q      <= jump_d;
            param_q     <= param_d;
            cycle_q     <= cycle_d;
            vec_valid_q <= vec_valid_d;
            wft_q       <= wft_d;
            period_q    <= period_d;
            wfc_q       <= wfc_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bp_q        <= bp_d;
            err_q       <= err_d;
        end
    end

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_addr     = mem_addr_q;
    assign vec_valid    = vec_valid_q;
    assign vec_wft      = wft_q;
    assign vec_period   = period_q;
    assign vec_wfc      = wfc_q;
    assign vector_index = index_q;
    assign cycle_number = cycle_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign breakpoint   = bp_q;
    assign op_error     = err_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: linear run, repeat, jump loop,
// stop with backpressure, abort, vec_count=0, REPEAT+JUMP error, async reset.
module tb_vector_sequencer;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned WFT_W    = 4;
    localparam int unsigned WFC_W    = 184;
    localparam int unsigned PERIOD_W = 32;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned DATA_W   = WFT_W + PERIOD_W + WFC_W;

    logic                clock = 1'b0;
    logic                reset;
    logic                start;
    logic                abort;
    logic [ADDR_W-1:0]   vec_count;
    logic                mem_rd_en;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_rd_data = '0;
    logic [3:0]          mem_rd_op = '0;
    logic [CNT_W-1:0]    mem_rd_param = '0;
    logic                vec_valid;
    logic                vec_ready;
    logic [WFT_W-1:0]    vec_wft;
    logic [PERIOD_W-1:0] vec_period;
    logic [WFC_W-1:0]    vec_wfc;
    logic [ADDR_W-1:0]   vector_index;
    logic [CNT_W-1:0]    cycle_number;
    logic                busy;
    logic                done;
    logic                breakpoint;
    logic                op_error;

    vector_sequencer #(
        .ADDR_W(ADDR_W), .WFT_W(WFT_W), .WFC_W(WFC_W),
        .PERIOD_W(PERIOD_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .vec_count(vec_count), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_op(mem_rd_op), .mem_rd_param(mem_rd_param),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_wft(vec_wft),
        .vec_period(vec_period), .vec_wfc(vec_wfc), .vector_index(vector_index),
        .cycle_number(cycle_number), .busy(busy), .done(done),
        .breakpoint(breakpoint), .op_error(op_error)
    );

    always #5 clock = ~clock;

    // Memory model: data fields derived from the address, op/param from tables
    logic [3:0]       op_mem  [0:(1<<ADDR_W)-1];
    logic [CNT_W-1:0] par_mem [0:(1<<ADDR_W)-1];

    function automatic logic [WFC_W-1:0] wfc_of(input logic [ADDR_W-1:0] a);
        return {a, 164'h0, ~a};
    endfunction

    always @(posedge clock) begin
        if (mem_rd_en) begin
            mem_rd_data  <= {mem_addr[3:0], 32'h100 + 32'(mem_addr), wfc_of(mem_addr)};
            mem_rd_op    <= op_mem[mem_addr];
            mem_rd_param <= par_mem[mem_addr];
        end
    end

    // Monitor: log accepted vectors, done pulses and memory reads
    int cyc = 0;
    int acc_idx[$];
    int acc_cyc[$];
    int done_cnt = 0;
    int rd_cnt   = 0;
    int bad_cnt  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (vec_valid && vec_ready) begin
            acc_idx.push_back(int'(vector_index));
            acc_cyc.push_back(cyc);
            if (vec_wft !== vector_index[3:0] ||
                vec_period !== 32'h100 + 32'(vector_index) ||
                vec_wfc !== wfc_of(vector_index))
                bad_cnt++;
        end
        if (done)      done_cnt++;
        if (mem_rd_en) rd_cnt++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        acc_idx.delete();
        acc_cyc.delete();
        done_cnt = 0;
        rd_cnt   = 0;
        bad_cnt  = 0;
    endtask

    task automatic wait_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (!busy) break;
            step(1);
        end
        check(tag, 64'(busy), 64'd0);
        step(2);
    endtask

    // Accepted index sequence packed one nibble per vector as (index+1)
    function automatic logic [63:0] seq_of_log();
        logic [63:0] s = '0;
        foreach (acc_idx[i]) s = (s << 4) | 64'(acc_idx[i] + 1);
        return s;
    endfunction

    function automatic int gap(input int i, input int j);
        if (acc_cyc.size() <= j) return -1;
        return acc_cyc[j] - acc_cyc[i];
    endfunction

    task automatic clear_ops();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            op_mem[i]  = 4'h0;
            par_mem[i] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int held_bad;

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; vec_ready = 1'b1; vec_count = '0;
        clear_ops();
        #23;
        check("rst_valid", 64'(vec_valid), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_rden",  64'(mem_rd_en), 64'd0);
        check("rst_cycle", 64'(cycle_number), 64'd0);
        check("rst_index", 64'(vector_index), 64'd0);
        check("rst_flags", 64'({breakpoint, op_error}), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        step(2);

        // Linear: three plain vectors, latency and bubble spacing
        vec_count = 10'd3;
        clear_log();
        pulse_start();
        check("lin_fetch_rden", 64'(mem_rd_en), 64'd1);
        check("lin_fetch_addr", 64'(mem_addr), 64'd0);
        check("lin_fetch_busy", 64'(busy), 64'd1);
        check("lin_fetch_valid", 64'(vec_valid), 64'd0);
        step(1);
        check("lin_load_valid", 64'(vec_valid), 64'd0);
        step(1);
        check("lin_issue_valid", 64'(vec_valid), 64'd1);
        check("lin_issue_period", 64'(vec_period), 64'h100);
        check("lin_issue_wfc", 64'(vec_wfc === wfc_of(10'd0)), 64'd1);
        wait_idle("lin_timeout", 100);
        check("lin_order", seq_of_log(), 64'h123);
        check("lin_cycle", 64'(cycle_number), 64'd3);
        check("lin_done", 64'(done_cnt), 64'd1);
        check("lin_gap", 64'(gap(0, 1)), 64'd3);
        check("lin_fields", 64'(bad_cnt), 64'd0);

        // Repeat: vec0 issued 4 times back-to-back, then vec1
        op_mem[0] = 4'h1; par_mem[0] = 32'd4;
        vec_count = 10'd2;
        clear_log();
        pulse_start();
        wait_idle("rep_timeout", 100);
        check("rep_order", seq_of_log(), 64'h11112);
        check("rep_cycle", 64'(cycle_number), 64'd5);
        check("rep_b2b", 64'(gap(0, 3)), 64'd3);
        check("rep_bubble", 64'(gap(3, 4)), 64'd3);
        check("rep_done", 64'(done_cnt), 64'd1);

        // Loop: mark at v0, jump at v1 with param 2
        clear_ops();
        op_mem[0] = 4'h8;
        op_mem[1] = 4'h4; par_mem[1] = 32'd2;
        vec_count = 10'd2;
        clear_log();
        pulse_start();
        wait_idle("loop_timeout", 200);
        check("loop_order", seq_of_log(), 64'h121212);
        check("loop_cycle", 64'(cycle_number), 64'd6);
        check("loop_done", 64'(done_cnt), 64'd1);

        // Stop with backpressure on v1
        clear_ops();
        op_mem[1] = 4'h2;
        vec_count = 10'd3;
        clear_log();
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (vec_valid && vector_index == 10'd1) break;
            step(1);
        end
        vec_ready = 1'b0;
        check("stop_reach_v1", 64'({vec_valid, vector_index}), 64'({1'b1, 10'd1}));
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (!vec_valid || vector_index != 10'd1 || vec_period != 32'h101 ||
                vec_wfc !== wfc_of(10'd1))
                held_bad++;
        end
        check("stop_held", 64'(held_bad), 64'd0);
        check("stop_cycle_held", 64'(cycle_number), 64'd1);
        vec_ready = 1'b1;
        step(1);
        check("stop_bp", 64'(breakpoint), 64'd1);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_valid", 64'(vec_valid), 64'd0);
        check("stop_cycle", 64'(cycle_number), 64'd2);
        step(3);
        check("stop_no_done", 64'(done_cnt), 64'd0);
        check("stop_order", seq_of_log(), 64'h12);

        // Abort mid-repeat after three accepts
        clear_ops();
        op_mem[0] = 4'h1; par_mem[0] = 32'd10;
        vec_count = 10'd1;
        clear_log();
        pulse_start();
        check("abort_bp_cleared", 64'(breakpoint), 64'd0);
        for (int i = 0; i < 50; i++) begin
            if (cycle_number == 32'd3) break;
            step(1);
        end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_valid", 64'(vec_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cycle", 64'(cycle_number), 64'd3);
        check("abort_rden", 64'(mem_rd_en), 64'd0);
        step(3);
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Abort and start together: start ignored
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("abst_busy", 64'(busy), 64'd0);
        check("abst_cycle_kept", 64'(cycle_number), 64'd3);
        step(1);
        check("abst_rden", 64'(mem_rd_en), 64'd0);

        // vec_count = 0: immediate done, no fetch
        vec_count = 10'd0;
        clear_log();
        pulse_start();
        check("vc0_done", 64'(done), 64'd1);
        check("vc0_busy", 64'(busy), 64'd0);
        check("vc0_cycle", 64'(cycle_number), 64'd0);
        step(1);
        check("vc0_done_pulse", 64'(done), 64'd0);
        step(2);
        check("vc0_no_read", 64'(rd_cnt), 64'd0);
        check("vc0_no_accept", 64'(acc_idx.size()), 64'd0);

        // op=5: REPEAT and JUMP together behaves as repeat, raises op_error
        clear_ops();
        op_mem[0] = 4'h5; par_mem[0] = 32'd3;
        vec_count = 10'd1;
        clear_log();
        pulse_start();
        wait_idle("err_timeout", 100);
        check("err_order", seq_of_log(), 64'h111);
        check("err_flag", 64'(op_error), 64'd1);
        check("err_cycle", 64'(cycle_number), 64'd3);
        check("err_done", 64'(done_cnt), 64'd1);
        check("err_bp", 64'(breakpoint), 64'd0);

        // Next start clears op_error; async reset mid-pattern clears all
        clear_ops();
        op_mem[0] = 4'h1; par_mem[0] = 32'd10;
        clear_log();
        pulse_start();
        check("clr_err", 64'(op_error), 64'd0);
        step(4);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(vec_valid), 64'd0);
        check("arst_cycle", 64'(cycle_number), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        step(3);
        check("arst_no_done", 64'(done_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
